// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one 32-bit memory bus between the instruction-fetch port and the
// load/store port. Data accesses have fixed priority over fetches. The granted
// request is registered onto the bus and held until the bus acknowledges.
// Read data is then captured and the owning port sees a one-cycle ack pulse.
// stallreq_o is raised towards the pipeline controller while any requester is
// still waiting.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to enable a bus watchdog.
// An access that gets no bus_ack_i for TIMEOUT cycles is then ended with
// zero data, an ack and err_o. Without the macro an access waits
// indefinitely and err_o stays 0.
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          asynchronous active-low reset
//   if_req_i     fetch request (level, held until if_ack_o)
//   if_addr_i    fetch address
//   if_data_o    fetched instruction, valid with if_ack_o, held between acks
//   if_ack_o     fetch done, one-cycle pulse
//   mem_req_i    data request (level, held until mem_ack_o)
//   mem_we_i     1 = store, 0 = load
//   mem_sel_i    byte enables
//   mem_addr_i   data address
//   mem_data_i   store data
//   mem_data_o   load data, valid with mem_ack_o, held between acks
//   mem_ack_o    data access done, one-cycle pulse
//   bus_req_o    bus cycle active
//   bus_we_o     bus write enable
//   bus_sel_o    bus byte enables
//   bus_addr_o   bus address
//   bus_wdata_o  bus write data
//   bus_rdata_i  bus read data, sampled with bus_ack_i
//   bus_ack_i    bus completion
//   err_o        watchdog timeout pulse, coincident with the faulting ack
//   stallreq_o   stall request to the pipeline controller (combinational)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              err_o,
    output logic              stallreq_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_ACC  = 2'b01,
        MEM_ACC = 2'b10
    } state_t;

    state_t state_r;
    state_t next_state_s;

    logic if_elig_s;
    logic mem_elig_s;
    logic grant_if_s;
    logic grant_mem_s;
    logic end_acc_s;
    logic err_s;
    logic tmo_s;

    logic              bus_req_r;
    logic              bus_we_r;
    logic [3:0]        bus_sel_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic [DATA_W-1:0] if_data_r;
    logic [DATA_W-1:0] mem_data_r;
    logic              if_ack_r;
    logic              mem_ack_r;
    logic              err_r;

    // A port is masked during its own ack cycle: its request is still high
    // there (held until ack) but has already been served.
    assign if_elig_s  = if_req_i & ~if_ack_r;
    assign mem_elig_s = mem_req_i & ~mem_ack_r;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The access ends on the edge where the counter would reach TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wdog_cnt_r;

    // Watchdog: cleared on grant, counts access cycles without bus_ack_i
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if (grant_if_s || grant_mem_s) begin
            wdog_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r != IDLE) && !bus_ack_i) begin
            wdog_cnt_r <= wdog_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            wdog_cnt_r <= wdog_cnt_r;
        end
    end

    assign tmo_s = (state_r != IDLE) && (wdog_cnt_r == TMO_LAST);
`else
    assign tmo_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state, grant and completion decode
    always_comb begin
        next_state_s = state_r;
        grant_if_s   = 1'b0;
        grant_mem_s  = 1'b0;
        end_acc_s    = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_elig_s) begin
                    next_state_s = MEM_ACC;
                    grant_mem_s  = 1'b1;
                end else if (if_elig_s) begin
                    next_state_s = IF_ACC;
                    grant_if_s   = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IF_ACC, MEM_ACC: begin
                // A real bus ack on the timeout edge takes precedence.
                if (bus_ack_i) begin
                    end_acc_s    = 1'b1;
                    next_state_s = IDLE;
                end else if (tmo_s) begin
                    end_acc_s    = 1'b1;
                    err_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Bus request latch, read data capture and ack/err pulse generation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_sel_r   <= 4'b0000;
            bus_addr_r  <= {ADDR_W{1'b0}};
            bus_wdata_r <= {DATA_W{1'b0}};
            if_data_r   <= {DATA_W{1'b0}};
            mem_data_r  <= {DATA_W{1'b0}};
            if_ack_r    <= 1'b0;
            mem_ack_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            if_ack_r  <= 1'b0;
            mem_ack_r <= 1'b0;
            err_r     <= 1'b0;
            if (grant_mem_s) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= mem_we_i;
                bus_sel_r   <= mem_sel_i;
                bus_addr_r  <= mem_addr_i;
                bus_wdata_r <= mem_data_i;
            end else if (grant_if_s) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b0;
                bus_sel_r   <= 4'b1111;
                bus_addr_r  <= if_addr_i;
                bus_wdata_r <= {DATA_W{1'b0}};
            end else if (end_acc_s) begin
                bus_req_r <= 1'b0;
                err_r     <= err_s;
                // Stores capture too; the port simply ignores the value.
                if (state_r == IF_ACC) begin
                    if_ack_r  <= 1'b1;
                    if_data_r <= err_s ? {DATA_W{1'b0}} : bus_rdata_i;
                end else begin
                    mem_ack_r  <= 1'b1;
                    mem_data_r <= err_s ? {DATA_W{1'b0}} : bus_rdata_i;
                end
            end else begin
                bus_req_r <= bus_req_r;
            end
        end
    end

    assign bus_req_o   = bus_req_r;
    assign bus_we_o    = bus_we_r;
    assign bus_sel_o   = bus_sel_r;
    assign bus_addr_o  = bus_addr_r;
    assign bus_wdata_o = bus_wdata_r;
    assign if_data_o   = if_data_r;
    assign mem_data_o  = mem_data_r;
    assign if_ack_o    = if_ack_r;
    assign mem_ack_o   = mem_ack_r;
    assign err_o       = err_r;

    // Stall while either port has a request that has not been acked yet.
    assign stallreq_o = (if_req_i & ~if_ack_r) | (mem_req_i & ~mem_ack_r);

endmodule
